uart_tx_ctrl: RTL

Serial transmitter for the team's UART link: accepts one parallel byte per handshake and shifts it out as a standard 8N1 frame (start bit, 8 data bits LSB first, stop bit) at a fixed bit period measured in clock cycles. It is the transmit-side peer of the receiver control unit. Its `serial_out` line drives the receiver's serial input, and its bit period matches the receiver's bit timer.

---
 rtl/uart_pkg.sv | 17 +
 rtl/tx_bit_timer.sv | 30 +++
 rtl/uart_tx_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive controllers.
//   tx_state_t  - transmitter FSM states
//   START_BIT / STOP_BIT / IDLE_LEVEL - 8N1 line levels
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: wrap-around counter 0..TERMINAL with enable and synchronous
// clear. Used both as the bit-period timer and as the data-bit index.
//   clk, rst : clock, async active-high reset (count clears to 0)
//   en       : advance the count this cycle
//   clr      : synchronous clear, wins over en
//   tc       : one-cycle strobe while enabled at the terminal count
module tx_bit_timer #(
  parameter int TERMINAL = 9,
  parameter int WIDTH    = $clog2(TERMINAL + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] cnt;

  assign tc = en && (cnt == TC_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tc ? '0 : cnt + WIDTH'(1);
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 serial transmitter. Accepts one DATA_BITS-wide word per
// tx_start/tx_ready handshake and shifts it out LSB first, framed by a start
// bit and a stop bit, each bit lasting CLKS_PER_BIT clock cycles.
//   clk, rst   : clock, async active-high reset
//   tx_start   : send request, only looked at while tx_ready=1
//   tx_data    : payload, captured on the accepting edge
//   tx_ready   : high only in IDLE
//   tx_done    : one-cycle pulse in the first IDLE cycle after a stop bit
//   serial_out : registered line output, idles high
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,  // 2..1023
  parameter int DATA_BITS    = 8    // 5..8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  tx_state_t            state, state_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic                 serial_q, serial_nxt;
  logic                 done_q, done_nxt;
  logic                 accept;
  logic                 bit_tc, idx_tc;

  assign accept = (state == IDLE) && tx_start;

  // Bit-period timer: cleared on acceptance so the start bit gets a full
  // period, then free-runs through START/DATA/STOP wrapping every period.
  tx_bit_timer #(
    .TERMINAL (CLKS_PER_BIT - 1),
    .WIDTH    (CNT_W)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .clr (accept),
    .tc  (bit_tc)
  );

  // Data-bit index: held at 0 through START so it is 0 on entry to DATA,
  // advanced once per bit period while in DATA.
  tx_bit_timer #(
    .TERMINAL (DATA_BITS - 1),
    .WIDTH    (IDX_W)
  ) u_bit_index (
    .clk (clk),
    .rst (rst),
    .en  ((state == DATA) && bit_tc),
    .clr (state == START),
    .tc  (idx_tc)
  );

  // serial_nxt is the line level for the cycle after this edge, derived from
  // the state being entered, so the output register adds no extra latency.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_q;
    serial_nxt = serial_q;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        serial_nxt = IDLE_LEVEL;
        if (tx_start) begin
          state_nxt  = START;
          shift_nxt  = tx_data;
          serial_nxt = START_BIT;
        end
      end
      START: begin
        serial_nxt = START_BIT;
        if (bit_tc) begin
          state_nxt  = DATA;
          serial_nxt = shift_q[0];
        end
      end
      DATA: begin
        serial_nxt = shift_q[0];
        if (bit_tc) begin
          shift_nxt = shift_q >> 1;
          if (idx_tc) begin
            state_nxt  = STOP;
            serial_nxt = STOP_BIT;
          end else begin
            serial_nxt = shift_q[1];
          end
        end
      end
      STOP: begin
        serial_nxt = STOP_BIT;
        if (bit_tc) begin
          state_nxt  = IDLE;
          serial_nxt = IDLE_LEVEL;
          done_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        serial_nxt = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      serial_q <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift_q  <= shift_nxt;
      serial_q <= serial_nxt;
      done_q   <= done_nxt;
    end
  end

  assign tx_ready   = (state == IDLE);
  assign tx_done    = done_q;
  assign serial_out = serial_q;

endmodule
